// File: rtl/parity_generator.sv
// rtl/parity_generator.sv - byte parity generator/checker with framing and error count
// Combinational parity, registered 9-bit frame generator, registered frame checker.
module parity_generator #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic                     even_parity,
  output logic                     odd_parity,
  input  logic                     parity_sel,
  input  logic                     tx_valid,
  input  logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     frame_valid,
  output logic [DATA_WIDTH:0]      frame_out,
  input  logic                     rx_valid,
  input  logic [DATA_WIDTH:0]      rx_frame,
  output logic                     chk_valid,
  output logic                     parity_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  logic rx_err;

  assign even_parity = ^data;
  assign odd_parity  = ~(^data);

  // Whole-frame XOR is 0 for an even ones-count; odd mode inverts the sense.
  assign rx_err = (^rx_frame) ^ parity_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_out   <= '0;
    end else begin
      frame_valid <= tx_valid;
      if (tx_valid) begin
        frame_out <= {(^tx_data) ^ parity_sel, tx_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid  <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      chk_valid  <= rx_valid;
      parity_err <= rx_valid & rx_err;
      if (rx_valid && rx_err && (err_count != {ERR_CNT_WIDTH{1'b1}})) begin
        err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_generator.sv
// tb/tb_parity_generator.sv - scoreboard bench for parity_generator
module tb_parity_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       even_parity, odd_parity;
  logic       parity_sel;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       frame_valid;
  logic [8:0] frame_out;
  logic       rx_valid;
  logic [8:0] rx_frame;
  logic       chk_valid;
  logic       parity_err;
  logic [15:0] err_count;

  logic       s_even, s_odd, s_frame_valid, s_chk_valid, s_parity_err;
  logic [8:0] s_frame_out;
  logic [3:0] s_err_count;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_frame_q[$];
  logic       exp_err_q[$];

  always #5 clk = ~clk;

  parity_generator dut (
    .clk(clk), .rst(rst), .data(data), .even_parity(even_parity), .odd_parity(odd_parity),
    .parity_sel(parity_sel), .tx_valid(tx_valid), .tx_data(tx_data),
    .frame_valid(frame_valid), .frame_out(frame_out), .rx_valid(rx_valid),
    .rx_frame(rx_frame), .chk_valid(chk_valid), .parity_err(parity_err),
    .err_count(err_count)
  );

  parity_generator #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .data(data), .even_parity(s_even), .odd_parity(s_odd),
    .parity_sel(parity_sel), .tx_valid(tx_valid), .tx_data(tx_data),
    .frame_valid(s_frame_valid), .frame_out(s_frame_out), .rx_valid(rx_valid),
    .rx_frame(rx_frame), .chk_valid(s_chk_valid), .parity_err(s_parity_err),
    .err_count(s_err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per output pulse
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_frame_q.size() == 0) begin
        check("frame_unexpected", 32'(frame_out), 32'h1ff);
      end else begin
        check("frame_out", 32'(frame_out), 32'(exp_frame_q.pop_front()));
      end
    end
    if (chk_valid === 1'b1) begin
      if (exp_err_q.size() == 0) begin
        check("chk_unexpected", 32'(parity_err), 32'h2);
      end else begin
        check("parity_err", 32'(parity_err), 32'(exp_err_q.pop_front()));
      end
    end
  end

  task automatic send_tx(input logic sel, input logic [7:0] b, input logic [8:0] exp);
    parity_sel = sel;
    tx_valid   = 1'b1;
    tx_data    = b;
    exp_frame_q.push_back(exp);
  endtask

  task automatic send_rx(input logic sel, input logic [8:0] f, input logic exp);
    parity_sel = sel;
    rx_valid   = 1'b1;
    rx_frame   = f;
    exp_err_q.push_back(exp);
  endtask

  task automatic idle();
    tx_valid = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [8:0] f;
    logic       sel;

    rst = 1'b1; data = '0; parity_sel = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_valid = 1'b0; rx_frame = '0;

    // Combinational parity
    data = 8'b0000_0000; #1;
    check("even_00", 32'(even_parity), 0); check("odd_00", 32'(odd_parity), 1); #9;
    data = 8'b0000_0001; #1;
    check("even_01", 32'(even_parity), 1); check("odd_01", 32'(odd_parity), 0); #9;
    data = 8'b1010_1010; #1;
    check("even_aa", 32'(even_parity), 0); check("odd_aa", 32'(odd_parity), 1); #9;
    data = 8'b1111_1111; #1;
    check("even_ff", 32'(even_parity), 0); check("odd_ff", 32'(odd_parity), 1); #9;

    // Reset overrides valids
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hff; rx_valid = 1'b1; rx_frame = 9'h001;
    step(); step();
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_frame_out", 32'(frame_out), 0);
    check("rst_chk_valid", 32'(chk_valid), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_err_count", 32'(err_count), 0);
    rst = 1'b0; idle();

    // Generator
    send_tx(1'b0, 8'h07, 9'h107); step();
    check("gen_latency_valid", 32'(frame_valid), 1);
    send_tx(1'b1, 8'h07, 9'h007); step();
    send_tx(1'b0, 8'h00, 9'h000); step();
    send_tx(1'b0, 8'hff, 9'h0ff); step();
    idle(); step();
    check("gen_valid_drop", 32'(frame_valid), 0);
    check("gen_hold", 32'(frame_out), 32'h0ff);

    // Checker
    send_rx(1'b0, 9'h107, 1'b0); step();
    send_rx(1'b0, 9'h007, 1'b1); step();
    check("chk_err_count_1", 32'(err_count), 1);
    send_rx(1'b1, 9'h007, 1'b0); step();
    check("chk_err_count_hold", 32'(err_count), 1);
    idle(); step();
    check("chk_idle_valid", 32'(chk_valid), 0);
    check("chk_idle_err", 32'(parity_err), 0);

    // Loopback with correct and then single-bit-corrupted frames
    do_reset();
    for (int i = 0; i < 256; i++) begin
      b   = 8'($urandom);
      sel = 1'($urandom);
      f   = {(^b) ^ sel, b};
      send_tx(sel, b, f);
      send_rx(sel, f, 1'b0);
      step();
    end
    idle(); step();
    check("loop_clean_count", 32'(err_count), 0);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      b   = 8'($urandom);
      sel = 1'($urandom);
      f   = {(^b) ^ sel, b};
      send_tx(sel, b, f);
      send_rx(sel, f ^ (9'h1 << $urandom_range(8, 0)), 1'b1);
      step();
    end
    idle(); step();
    check("loop_flip_count", 32'(err_count), 256);
    check("loop_flip_sat4", 32'(s_err_count), 15);

    // Saturation of the 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_rx(1'b0, 9'h001, 1'b1);
      step();
      if (i == 14) check("sat_reach_15", 32'(s_err_count), 15);
    end
    idle(); step();
    check("sat_stay_15", 32'(s_err_count), 15);
    check("sat_wide_20", 32'(err_count), 20);
    rst = 1'b1; step(); rst = 1'b0;
    check("sat_rst", 32'(s_err_count), 0);
    check("sat_rst_wide", 32'(err_count), 0);

    step(); step();
    check("frame_q_drained", 32'(exp_frame_q.size()), 0);
    check("err_q_drained", 32'(exp_err_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_generator.md
Name: parity_generator

Overview:
- Parity generator/checker for a byte-wide datapath.
- Combinational even/odd parity of `data` for immediate use.
- Registered generator path: appends the selected parity bit to a valid byte, producing a 9-bit frame.
- Registered checker path: verifies incoming 9-bit frames and counts parity errors.
- Sits between the byte source and the serial/link framing logic.

Parameters:
- DATA_WIDTH, 8, width of `data`, `tx_data` and `rx_frame` payload; must be ≥ 1.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  DATA_WIDTH  byte for combinational parity.
- even_parity  output  1  bit that makes ones-count of {data, bit} even; equals XOR-reduce of `data`.
- odd_parity  output  1  bit that makes ones-count of {data, bit} odd; always ~even_parity.
- parity_sel  input  1  0 = even parity, 1 = odd parity; applies to both generator and checker.
- tx_valid  input  1  qualifies `tx_data`.
- tx_data  input  DATA_WIDTH  byte to frame.
- frame_valid  output  1  registered; high one cycle per accepted `tx_valid`.
- frame_out  output  DATA_WIDTH+1  registered {parity_bit, tx_data}; parity in the MSB.
- rx_valid  input  1  qualifies `rx_frame`.
- rx_frame  input  DATA_WIDTH+1  received {parity_bit, payload}.
- chk_valid  output  1  registered; high one cycle per accepted `rx_valid`.
- parity_err  output  1  registered; valid when `chk_valid` is high, else 0.
- err_count  output  ERR_CNT_WIDTH  saturating count of detected parity errors.

Behaviour:
- Combinational path:
  - `even_parity` = ^data; `odd_parity` = ~^data.
  - Zero latency, independent of clk, rst and parity_sel.
- Generator:
  - On a clk edge with tx_valid=1: frame_out <= {(^tx_data) ^ parity_sel, tx_data}; frame_valid <= 1.
  - With tx_valid=0: frame_valid <= 0 and frame_out holds its last value.
  - Latency is 1 cycle. Back-to-back valids are accepted every cycle; there is no backpressure.
- Checker:
  - On a clk edge with rx_valid=1: chk_valid <= 1 and parity_err <= (^rx_frame) ^ parity_sel.
  - For even mode, a correct frame has an even total ones-count. For odd mode, it has an odd total ones-count.
  - With rx_valid=0: chk_valid <= 0 and parity_err <= 0.
- Error counter:
  - Increments by 1 on each edge where rx_valid=1 and a parity error is computed.
  - Saturates at all-ones and does not wrap.
- Independence:
  - Generator and checker operate independently; simultaneous tx_valid and rx_valid are both processed in the same cycle.
- parity_sel:
  - Sampled in the same cycle as the corresponding valid.
  - A change between cycles affects only later transactions.
- Reset (rst=1 at clk edge):
  - frame_valid=0, frame_out=0, chk_valid=0, parity_err=0, err_count=0.
  - Reset overrides valids in the same cycle; those transactions are dropped.
  - Combinational outputs are unaffected by reset.
  - Mid-operation reset drops any in-flight output pulse.
- No X propagation from registered outputs after the first reset.

Test Plan:
- Combinational path, stepping `data` every 10 ns:
  - data=8'b00000000 -> even_parity=0, odd_parity=1.
  - 8'b00000001 -> 1/0.
  - 8'b10101010 -> 0/1.
  - 8'b11111111 -> 0/1.
- Reset:
  - Hold rst=1 for 2 cycles with tx_valid=rx_valid=1 -> all registered outputs 0 and err_count=0.
  - After release, the first valid transaction appears one cycle later.
- Generator, even then odd mode:
  - parity_sel=0, tx_data=8'h07 -> next cycle frame_out=9'h107, frame_valid=1.
  - parity_sel=1, tx_data=8'h07 -> frame_out=9'h007.
  - Back-to-back 8'h00, 8'hFF in even mode -> 9'h000, 9'h0FF on consecutive cycles.
- Checker:
  - parity_sel=0, rx_frame=9'h107 -> parity_err=0.
  - rx_frame=9'h007 -> parity_err=1 and err_count=1.
  - parity_sel=1, rx_frame=9'h007 -> parity_err=0, err_count unchanged.
- Loopback:
  - frame_out fed to rx_frame with matching parity_sel over 256 random bytes -> err_count stays 0.
  - Flip one bit per frame -> err_count=256.
- Saturation: with ERR_CNT_WIDTH=4, apply 20 bad frames -> err_count=15 and stays 15; assert rst -> 0.
